// File: rtl/core_pkg.sv
// Shared core types for the fetch stage: widths, the NOP encoding, the
// fetch-queue entry layout and the fetch-control FSM states.
package core_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            err;
  } fetch_entry_t;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_e;

  // Instruction addresses are always word aligned.
  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with push, pop and flush.
// Used both as the instruction queue and as the in-flight address tag FIFO.
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    entries [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = entries[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; validity is tracked by count, so clearing
    // the array would only add reset fan-out.
    if (do_push && !flush) entries[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage feeding the IF/ID register: owns the fetch PC,
// issues imem requests under a credit limit, queues returned instructions
// and discards wrong-path responses after branch/jump or trap redirects.
// Optional: define FETCH_PERF_CNT_EN to add fetch/bubble performance counters.
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] NOP_INST = core_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        bj_en,
  input  logic [63:0] bj_target,
  input  logic        trap_en,
  input  logic [63:0] trap_target,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic [31:0] inst_out,
  output logic [63:0] pc_out,
  output logic        fetch_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_bubble_cnt
`endif
);

  import core_pkg::*;

  localparam int            CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0]   QD = (CW + 1)'(QDEPTH);

  logic [63:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop;
  fetch_state_e  state;
  fetch_state_e  state_next;

  logic          redirect;
  logic [63:0]   target;
  logic          accept;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          q_pop;

  fetch_entry_t  tag_din;
  fetch_entry_t  tag_head;
  fetch_entry_t  q_din;
  fetch_entry_t  q_head;
  logic [CW-1:0] tag_count;
  logic [CW-1:0] q_count;
  logic          tag_full;
  logic          tag_empty;
  logic          q_full;
  logic          q_empty;
  logic          tag_unused;

  assign redirect  = bj_en | trap_en;
  assign target    = align4(trap_en ? trap_target : bj_target);

  // Issue only while every in-flight response is guaranteed a queue slot.
  assign req_valid = ~rst & ~redirect &
                     (({1'b0, outstanding} + {1'b0, q_count}) < QD);
  assign req_addr  = pc;
  assign accept    = req_valid & req_ready;

  assign rsp_drop  = rsp_valid & (drop != '0);
  assign rsp_keep  = rsp_valid & (drop == '0);
  assign q_pop     = ~stall & ~q_empty & ~redirect;

  assign outstanding_next = outstanding + CW'(accept) - CW'(rsp_valid);

  assign tag_din = '{pc: pc, inst: '0, err: 1'b0};
  assign q_din   = '{pc: tag_head.pc, inst: (rsp_err ? NOP_INST : rsp_data), err: rsp_err};

  assign inst_out  = q_empty ? NOP_INST : q_head.inst;
  assign pc_out    = q_empty ? 64'd0    : q_head.pc;
  assign fetch_err = q_empty ? 1'b0     : q_head.err;

  // The tag FIFO only carries addresses; its other fields and flags are unused.
  assign tag_unused = ^{tag_count, tag_full, tag_empty, tag_head.inst, tag_head.err, q_full};

  // Fetch PC, in-flight count and wrong-path drop count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect)    pc <= target;
      else if (accept) pc <= pc + 64'd4;
      if (redirect)      drop <= outstanding_next;
      else if (rsp_drop) drop <= drop - CW'(1);
    end
  end

  // Fetch-control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next state: drain while wrong-path responses remain in flight.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    case (state)
      RUN: begin
        if (redirect && (outstanding_next != '0)) state_next = DRAIN;
      end
      DRAIN: begin
        if (redirect)                              state_next = (outstanding_next != '0) ? DRAIN : RUN;
        else if (rsp_drop && (drop == CW'(1)))     state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (rsp_keep),
    .flush (redirect),
    .din   (tag_din),
    .dout  (tag_head),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  fetch_queue #(.DEPTH(QDEPTH)) u_inst_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (q_pop),
    .flush (redirect),
    .din   (q_din),
    .dout  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

`ifdef FETCH_PERF_CNT_EN
  // Delivered-entry and downstream-bubble counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (q_pop)              perf_fetch_cnt  <= perf_fetch_cnt + 64'd1;
      if (!stall && q_empty)  perf_bubble_cnt <= perf_bubble_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed phases push hand-computed expected
// {pc, inst, err} entries; a behavioural imem answers accepted requests; a
// monitor pops and compares every entry the DUT hands to IF/ID.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        bj_en;
  logic [63:0] bj_target;
  logic        trap_en;
  logic [63:0] trap_target;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] inst_out;
  logic [63:0] pc_out;
  logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_bubble_cnt;
`endif

  if_fetch #(.RESET_PC(64'h0000_0000_8000_0000), .QDEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .bj_en       (bj_en),
    .bj_target   (bj_target),
    .trap_en     (trap_en),
    .trap_target (trap_target),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .fetch_err   (fetch_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] pend[$];
  int          checks = 0;
  int          passes = 0;
  int          grant_left = 0;
  int          acc_total = 0;
  bit          rsp_hold = 1'b0;
  logic [63:0] err_addr = '1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  task automatic expect_fetch(input logic [63:0] a, input logic e);
    exp_t x;
    x.pc   = a;
    x.inst = e ? NOP : mem_word(a);
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    stall = 1'b0;
    bj_en = 1'b0;
    trap_en = 1'b0;
    bj_target = '0;
    trap_target = '0;
    grant_left = 0;
    rsp_hold = 1'b0;
    err_addr = '1;
    acc_total = 0;
    repeat (2) tick();
  endtask

  // Behavioural imem: grants a budget of requests, answers in order one
  // cycle after acceptance unless held.
  initial begin
    logic [63:0] a;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    req_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) pend.delete();
      else if (req_valid && req_ready) begin
        pend.push_back(req_addr);
        grant_left--;
        acc_total++;
      end
      @(posedge clk);
      #2;
      if (!rst && !rsp_hold && pend.size() > 0) begin
        a = pend.pop_front();
        rsp_valid = 1'b1;
        rsp_data  = mem_word(a);
        rsp_err   = (a == err_addr);
      end else begin
        rsp_valid = 1'b0;
      end
      req_ready = !rst && (grant_left > 0);
    end
  end

  // Monitor: every dequeue seen by IF/ID is compared with the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !stall && !bj_en && !trap_en && pc_out != 64'd0) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_deq: got pc %h expected no entry", pc_out);
        end else begin
          e = exp_q.pop_front();
          check("deq_pc", pc_out, e.pc);
          check("deq_inst", 64'(inst_out), 64'(e.inst));
          check("deq_err", 64'(fetch_err), 64'(e.err));
        end
      end else if (!rst && pc_out == 64'd0) begin
        check("empty_inst", 64'(inst_out), 64'(NOP));
        check("empty_err", 64'(fetch_err), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    stall = 1'b0;
    bj_en = 1'b0;
    trap_en = 1'b0;
    bj_target = '0;
    trap_target = '0;
    #1 rst = 1'b1;

    // Reset state and streaming fetch.
    repeat (3) tick();
    @(negedge clk);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_inst_out", 64'(inst_out), 64'(NOP));
    check("rst_pc_out", pc_out, 64'd0);
    check("rst_fetch_err", 64'(fetch_err), 64'd0);
    tick();
    grant_left = 4;
    for (int i = 0; i < 4; i++) expect_fetch(64'h8000_0000 + 64'(4 * i), 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", 64'(req_valid), 64'd1);
    check("first_req_addr", req_addr, 64'h8000_0000);
    wait_drain("stream_drain");

    // Stall: issue stops at the credit limit, then resumes losslessly.
    do_reset();
    stall = 1'b1;
    grant_left = 6;
    for (int i = 0; i < 6; i++) expect_fetch(64'h8000_0000 + 64'(4 * i), 1'b0);
    rst = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("stall_req_valid", 64'(req_valid), 64'd0);
    check("stall_head_pc", pc_out, 64'h8000_0000);
    check("stall_accepts", 64'(acc_total), 64'd2);
    tick();
    stall = 1'b0;
    wait_drain("stall_drain");

    // Back-pressure: request held stable until accepted.
    do_reset();
    grant_left = 2;
    expect_fetch(64'h8000_0000, 1'b0);
    expect_fetch(64'h8000_0004, 1'b0);
    rst = 1'b0;
    wait_drain("hold_pre_drain");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_req_valid", 64'(req_valid), 64'd1);
      check("hold_req_addr", req_addr, 64'h8000_0008);
    end
    tick();
    grant_left = 1;
    expect_fetch(64'h8000_0008, 1'b0);
    wait_drain("hold_drain");
    check("hold_accepts", 64'(acc_total), 64'd3);

    // Branch redirect with two requests in flight.
    do_reset();
    rsp_hold = 1'b1;
    grant_left = 2;
    rst = 1'b0;
    n = 0;
    while (acc_total < 2 && n < 20) begin
      tick();
      n++;
    end
    check("redir_inflight", 64'(acc_total), 64'd2);
    bj_en = 1'b1;
    bj_target = 64'h8000_0100;
    grant_left = 2;
    expect_fetch(64'h8000_0100, 1'b0);
    expect_fetch(64'h8000_0104, 1'b0);
    @(negedge clk);
    check("redir_no_req", 64'(req_valid), 64'd0);
    tick();
    bj_en = 1'b0;
    rsp_hold = 1'b0;
    @(negedge clk);
    check("redir_addr", req_addr, 64'h8000_0100);
    wait_drain("redir_drain");

    // Simultaneous trap and branch: trap wins, target aligned.
    do_reset();
    rst = 1'b0;
    tick();
    bj_en = 1'b1;
    bj_target = 64'h1000;
    trap_en = 1'b1;
    trap_target = 64'h2003;
    @(negedge clk);
    check("both_no_req", 64'(req_valid), 64'd0);
    tick();
    bj_en = 1'b0;
    trap_en = 1'b0;
    @(negedge clk);
    check("both_req_valid", 64'(req_valid), 64'd1);
    check("both_req_addr", req_addr, 64'h2000);
    tick();
    grant_left = 1;
    expect_fetch(64'h2000, 1'b0);
    wait_drain("both_drain");

    // Access fault on the second fetch; fetching continues.
    do_reset();
    err_addr = 64'h8000_0004;
    grant_left = 3;
    expect_fetch(64'h8000_0000, 1'b0);
    expect_fetch(64'h8000_0004, 1'b1);
    expect_fetch(64'h8000_0008, 1'b0);
    rst = 1'b0;
    wait_drain("err_drain");

    repeat (3) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
